fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It buffers returned words in a 2-entry queue and presents one instruction per cycle, with its PC, to `control_logic`. Taken branches and jumps, signalled by `pc_sel` and the ALU target, redirect the fetch; fetches already in flight are squashed, and a NOP (`32'h00000000`) is inserted whenever no valid instruction is available.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, issues word
// fetches over a request/grant/response port, buffers kept responses in a
// 2-entry FIFO and presents one instruction (or a NOP) per cycle with its PC.
//
// Handshake: a request is transferred on a cycle where imem_req_o and
// imem_gnt_i are both high. Once raised, imem_req_o/imem_addr_o hold until
// that cycle, except in a redirect cycle, which withdraws the request.
// Responses come back in request order, one per imem_rvalid_i cycle, and
// are never back-pressured.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        pc_sel_i,
  input  logic [31:0] alu_target_i,
  input  logic        stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o
);

  // Architectural state
  logic [31:0] pc_q;
  logic [1:0]  live_cnt;
  logic [1:0]  drop_cnt;
  logic [1:0]  fifo_cnt;
  logic [31:0] pend_pc0, pend_pc1;
  logic [31:0] fifo_pc0, fifo_pc1;
  logic [31:0] fifo_inst0, fifo_inst1;

  // Next-state values
  logic [31:0] pc_d;
  logic [1:0]  live_d, drop_d, fifo_d;
  logic [31:0] pend_pc0_d, pend_pc1_d;
  logic [31:0] fifo_pc0_d, fifo_pc1_d;
  logic [31:0] fifo_inst0_d, fifo_inst1_d;
  logic [31:0] inst_d, pc_out_d;

  logic [2:0]  credit_used;
  logic        accept;
  logic        resp_keep;
  logic        resp_drop;
  logic [1:0]  live_tmp;
  logic [1:0]  fifo_tmp;

  // Low target bits are forced to zero on a redirect.
  logic        unused_target_bits;
  assign unused_target_bits = ^alu_target_i[1:0];

  // Credits: every granted-but-unanswered request and every buffered word
  // consumes one of two slots, which keeps the FIFO from overflowing.
  assign credit_used = {1'b0, live_cnt} + {1'b0, drop_cnt} + {1'b0, fifo_cnt};
  assign imem_req_o  = rst_n && !pc_sel_i && (credit_used < 3'd2);
  assign imem_addr_o = pc_q;
  assign accept      = imem_req_o && imem_gnt_i;
  assign resp_drop   = imem_rvalid_i && (drop_cnt != 2'd0);
  assign resp_keep   = imem_rvalid_i && (drop_cnt == 2'd0);
  assign pc4_o       = pc_o + 32'd4;

  // Next-state for PC, counters, pending-PC queue, FIFO and output registers
  always_comb begin
    pc_d         = pc_q;
    live_d       = live_cnt;
    drop_d       = drop_cnt;
    fifo_d       = fifo_cnt;
    pend_pc0_d   = pend_pc0;
    pend_pc1_d   = pend_pc1;
    fifo_pc0_d   = fifo_pc0;
    fifo_pc1_d   = fifo_pc1;
    fifo_inst0_d = fifo_inst0;
    fifo_inst1_d = fifo_inst1;
    inst_d       = inst_o;
    pc_out_d     = pc_o;
    live_tmp     = live_cnt;
    fifo_tmp     = fifo_cnt;

    if (pc_sel_i) begin
      // Redirect: every outstanding response becomes a drop, including the
      // one (if any) arriving right now, which retires immediately.
      pc_d     = {alu_target_i[31:2], 2'b00};
      live_d   = 2'd0;
      drop_d   = drop_cnt + live_cnt - {1'b0, imem_rvalid_i};
      fifo_d   = 2'd0;
      inst_d   = 32'd0;
      pc_out_d = 32'd0;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (resp_drop) begin
        drop_d = drop_cnt - 2'd1;
      end

      // Pending-PC queue: pop the head on a kept response, push on accept.
      if (resp_keep) begin
        pend_pc0_d = pend_pc1;
        live_tmp   = live_cnt - 2'd1;
      end
      if (accept) begin
        if (live_tmp == 2'd0) begin
          pend_pc0_d = pc_q;
        end else begin
          pend_pc1_d = pc_q;
        end
        live_tmp = live_tmp + 2'd1;
      end
      live_d = live_tmp;

      if (stall_i) begin
        // Outputs hold; kept words queue up behind the FIFO contents.
        if (resp_keep) begin
          if (fifo_cnt == 2'd0) begin
            fifo_pc0_d   = pend_pc0;
            fifo_inst0_d = imem_rdata_i;
          end else begin
            fifo_pc1_d   = pend_pc0;
            fifo_inst1_d = imem_rdata_i;
          end
          fifo_d = fifo_cnt + 2'd1;
        end
      end else if (fifo_cnt != 2'd0) begin
        // Present the oldest buffered word; a same-cycle response is queued.
        inst_d       = fifo_inst0;
        pc_out_d     = fifo_pc0;
        fifo_pc0_d   = fifo_pc1;
        fifo_inst0_d = fifo_inst1;
        fifo_tmp     = fifo_cnt - 2'd1;
        if (resp_keep) begin
          if (fifo_tmp == 2'd0) begin
            fifo_pc0_d   = pend_pc0;
            fifo_inst0_d = imem_rdata_i;
          end else begin
            fifo_pc1_d   = pend_pc0;
            fifo_inst1_d = imem_rdata_i;
          end
          fifo_tmp = fifo_tmp + 2'd1;
        end
        fifo_d = fifo_tmp;
      end else if (resp_keep) begin
        // Empty FIFO: bypass the response straight to the outputs.
        inst_d   = imem_rdata_i;
        pc_out_d = pend_pc0;
      end else begin
        inst_d   = 32'd0;
        pc_out_d = 32'd0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      live_cnt   <= 2'd0;
      drop_cnt   <= 2'd0;
      fifo_cnt   <= 2'd0;
      pend_pc0   <= 32'd0;
      pend_pc1   <= 32'd0;
      fifo_pc0   <= 32'd0;
      fifo_pc1   <= 32'd0;
      fifo_inst0 <= 32'd0;
      fifo_inst1 <= 32'd0;
      inst_o     <= 32'd0;
      pc_o       <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      live_cnt   <= live_d;
      drop_cnt   <= drop_d;
      fifo_cnt   <= fifo_d;
      pend_pc0   <= pend_pc0_d;
      pend_pc1   <= pend_pc1_d;
      fifo_pc0   <= fifo_pc0_d;
      fifo_pc1   <= fifo_pc1_d;
      fifo_inst0 <= fifo_inst0_d;
      fifo_inst1 <= fifo_inst1_d;
      inst_o     <= inst_d;
      pc_o       <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A small in-order memory
// model returns addr + 0x100 as data with a configurable response latency.
module tb_fetch_unit;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        pc_sel_i;
  logic [31:0] alu_target_i;
  logic        stall_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_sel_i      (pc_sel_i),
    .alu_target_i  (alu_target_i),
    .stall_i       (stall_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory model state: outstanding addresses and their response cycles
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mem_lat = 1;
  logic        gnt_en  = 1'b1;

  // Request seen during the most recent cycle
  logic        a_req;
  logic [31:0] a_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory side, record the request, check invariants
  task automatic tick();
    int used;
    imem_gnt_i = gnt_en;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mq_addr[0] + 32'h100;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'd0;
    end
    #1;
    a_req  = imem_req_o;
    a_addr = imem_addr_o;
    if (rst_n) begin
      used = int'(dut.live_cnt) + int'(dut.drop_cnt) + int'(dut.fifo_cnt);
      check_eq("credit_bound", 32'(used <= 2), 32'd1);
      check_eq("rsp_protocol",
               32'(imem_rvalid_i && dut.live_cnt == 2'd0 && dut.drop_cnt == 2'd0), 32'd0);
    end
    if (imem_req_o && imem_gnt_i) begin
      mq_addr.push_back(imem_addr_o);
      mq_due.push_back(cyc + mem_lat);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check_eq({tag, "_inst"}, inst_o, inst);
    check_eq({tag, "_pc"}, pc_o, pc);
    check_eq({tag, "_pc4"}, pc4_o, pc + 32'd4);
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, "_req"}, 32'(a_req), 32'(req));
    if (req) check_eq({tag, "_addr"}, a_addr, addr);
  endtask

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    pc_sel_i      = 1'b0;
    alu_target_i  = 32'd0;
    stall_i       = 1'b0;
    #1;
    check_out("reset", 32'd0, 32'd0);
    check_eq("reset_req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Zero-wait streaming from reset
    tick(); check_req("s0", 1'b1, 32'h0);
    tick(); check_req("s1", 1'b1, 32'h4); check_out("s1", 32'h100, 32'h0);
    tick(); check_req("s2", 1'b1, 32'h8); check_out("s2", 32'h104, 32'h4);
    tick(); check_out("s3", 32'h108, 32'h8);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #2;
    check_out("areset", 32'd0, 32'd0);
    check_eq("areset_req", 32'(imem_req_o), 32'd0);
    mq_addr.delete();
    mq_due.delete();
    imem_rvalid_i = 1'b0;
    gnt_en        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Grant withheld for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check_req("nognt", 1'b1, 32'h0);
      check_out("nognt", 32'd0, 32'd0);
    end
    gnt_en = 1'b1;
    tick(); check_req("g0", 1'b1, 32'h0); check_out("g0", 32'd0, 32'd0);
    tick(); check_req("g1", 1'b1, 32'h4); check_out("g1", 32'h100, 32'h0);
    tick(); check_req("g2", 1'b1, 32'h8); check_out("g2", 32'h104, 32'h4);

    // Stall for four cycles while streaming
    stall_i = 1'b1;
    tick(); check_req("st1", 1'b1, 32'hC); check_out("st1", 32'h104, 32'h4);
    for (int i = 2; i <= 4; i++) begin
      tick(); check_req("stn", 1'b0, 32'h0); check_out("stn", 32'h104, 32'h4);
    end
    stall_i = 1'b0;
    tick(); check_req("rl1", 1'b0, 32'h0);  check_out("rl1", 32'h108, 32'h8);
    tick(); check_req("rl2", 1'b1, 32'h10); check_out("rl2", 32'h10C, 32'hC);
    tick(); check_req("rl3", 1'b1, 32'h14); check_out("rl3", 32'h110, 32'h10);
    tick(); check_req("rl4", 1'b1, 32'h18); check_out("rl4", 32'h114, 32'h14);

    // Redirect with two fetches outstanding (slow memory)
    mem_lat = 3;
    tick(); check_req("rd1", 1'b1, 32'h1C); check_out("rd1", 32'h118, 32'h18);
    tick(); check_req("rd2", 1'b1, 32'h20); check_out("rd2", 32'd0, 32'd0);
    pc_sel_i     = 1'b1;
    alu_target_i = 32'h0000_0043;
    tick(); check_req("rd3", 1'b0, 32'h0);  check_out("rd3", 32'd0, 32'd0);
    check_eq("rd3_next_addr", imem_addr_o, 32'h40);
    pc_sel_i = 1'b0;
    tick(); check_req("rd4", 1'b0, 32'h0);  check_out("rd4", 32'd0, 32'd0);
    tick(); check_req("rd5", 1'b1, 32'h40); check_out("rd5", 32'd0, 32'd0);
    tick(); check_req("rd6", 1'b1, 32'h44); check_out("rd6", 32'd0, 32'd0);
    tick(); check_req("rd7", 1'b0, 32'h0);  check_out("rd7", 32'd0, 32'd0);
    mem_lat = 1;
    tick(); check_out("rd8", 32'h140, 32'h40);
    tick(); check_req("rd9", 1'b1, 32'h48); check_out("rd9", 32'h144, 32'h44);

    // Redirect together with stall while the FIFO holds two words
    stall_i = 1'b1;
    tick(); check_req("ss1", 1'b1, 32'h4C); check_out("ss1", 32'h144, 32'h44);
    tick(); check_req("ss2", 1'b0, 32'h0);  check_out("ss2", 32'h144, 32'h44);
    pc_sel_i     = 1'b1;
    alu_target_i = 32'h0000_0200;
    tick(); check_out("ss3", 32'd0, 32'd0);
    pc_sel_i = 1'b0;
    stall_i  = 1'b0;
    tick(); check_req("ss4", 1'b1, 32'h200); check_out("ss4", 32'd0, 32'd0);
    tick(); check_req("ss5", 1'b1, 32'h204); check_out("ss5", 32'h300, 32'h200);

    // Address wrap at the top of the address space
    pc_sel_i     = 1'b1;
    alu_target_i = 32'hFFFF_FFFC;
    tick(); check_req("wr1", 1'b0, 32'h0); check_out("wr1", 32'd0, 32'd0);
    pc_sel_i = 1'b0;
    tick(); check_req("wr2", 1'b1, 32'hFFFF_FFFC); check_out("wr2", 32'd0, 32'd0);
    tick(); check_req("wr3", 1'b1, 32'h0);
    check_out("wr3", 32'h0000_00FC, 32'hFFFF_FFFC);
    check_eq("wr3_pc4_wrap", pc4_o, 32'h0);
    tick(); check_out("wr4", 32'h100, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
